// File: rtl/axi3_ocm_slave.sv
// AXI3 responder backed by an internal 32-bit word RAM.
// Independent read/write channels, one outstanding burst per direction.
module axi3_ocm_slave #(
   parameter logic [31:0] BASE_ADDR = 32'hfffc0000,
   parameter int          MEM_AW    = 10,
   parameter int          ID_W      = 12
) (
   input  logic            AXI_clk,
   input  logic            rst,
   input  logic [31:0]     AXI_awaddr,
   input  logic [ID_W-1:0] AXI_awid,
   input  logic [3:0]      AXI_awlen,
   input  logic [2:0]      AXI_awsize,
   input  logic [1:0]      AXI_awburst,
   input  logic            AXI_awvalid,
   output logic            AXI_awready,
   input  logic [31:0]     AXI_wdata,
   input  logic [3:0]      AXI_wstrb,
   input  logic            AXI_wlast,
   input  logic            AXI_wvalid,
   output logic            AXI_wready,
   output logic [ID_W-1:0] AXI_bid,
   output logic [1:0]      AXI_bresp,
   output logic            AXI_bvalid,
   input  logic            AXI_bready,
   input  logic [31:0]     AXI_araddr,
   input  logic [ID_W-1:0] AXI_arid,
   input  logic [3:0]      AXI_arlen,
   input  logic [2:0]      AXI_arsize,
   input  logic [1:0]      AXI_arburst,
   input  logic            AXI_arvalid,
   output logic            AXI_arready,
   output logic [31:0]     AXI_rdata,
   output logic [ID_W-1:0] AXI_rid,
   output logic [1:0]      AXI_rresp,
   output logic            AXI_rlast,
   output logic            AXI_rvalid,
   input  logic            AXI_rready
);

   localparam int          DEPTH  = 1 << MEM_AW;
   localparam logic [31:0] WIN    = 32'(4 * DEPTH);
   localparam logic [1:0]  OKAY   = 2'b00;
   localparam logic [1:0]  SLVERR = 2'b10;
   localparam logic [1:0]  DECERR = 2'b11;

   typedef logic [MEM_AW-1:0] idx_t;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

   // Decode errors take precedence over malformed-burst errors.
   function automatic logic [1:0] burst_resp(
      input logic [31:0] a,
      input logic [2:0]  sz,
      input logic [1:0]  bt
   );
      logic [31:0] off;
      logic [1:0]  r;
      off = a - BASE_ADDR;
      if (a < BASE_ADDR || off >= WIN)
         r = DECERR;
      else if (sz != 3'b010 || bt != 2'b01)
         r = SLVERR;
      else
         r = OKAY;
      return r;
   endfunction

   function automatic idx_t word_idx(input logic [31:0] a);
      return idx_t'((a - BASE_ADDR) >> 2);
   endfunction

   logic [31:0] mem [DEPTH];

   // ---------------- write channel ----------------
   wstate_t         wstate_q, wstate_d;
   idx_t            w_idx_q, w_idx_d;
   logic [3:0]      w_len_q, w_len_d;
   logic [4:0]      w_cnt_q, w_cnt_d;
   logic [1:0]      bresp_q, bresp_d;
   logic [ID_W-1:0] bid_q, bid_d;
   logic            mem_we;

   always_ff @(posedge AXI_clk or posedge rst) begin
      if (rst) begin
         wstate_q <= W_IDLE;
         w_idx_q  <= '0;
         w_len_q  <= '0;
         w_cnt_q  <= '0;
         bresp_q  <= OKAY;
         bid_q    <= '0;
      end else begin
         wstate_q <= wstate_d;
         w_idx_q  <= w_idx_d;
         w_len_q  <= w_len_d;
         w_cnt_q  <= w_cnt_d;
         bresp_q  <= bresp_d;
         bid_q    <= bid_d;
      end
   end

   always_comb begin
      wstate_d    = wstate_q;
      w_idx_d     = w_idx_q;
      w_len_d     = w_len_q;
      w_cnt_d     = w_cnt_q;
      bresp_d     = bresp_q;
      bid_d       = bid_q;
      AXI_awready = 1'b0;
      AXI_wready  = 1'b0;
      AXI_bvalid  = 1'b0;
      mem_we      = 1'b0;
      unique case (wstate_q)
         W_IDLE: begin
            AXI_awready = !rst;
            if (AXI_awvalid && !rst) begin
               w_idx_d  = word_idx(AXI_awaddr);
               w_len_d  = AXI_awlen;
               w_cnt_d  = '0;
               bresp_d  = burst_resp(AXI_awaddr, AXI_awsize,
                                     AXI_awburst);
               bid_d    = AXI_awid;
               wstate_d = W_DATA;
            end
         end
         W_DATA: begin
            AXI_wready = 1'b1;
            if (AXI_wvalid) begin
               // Counter saturates at 16 so surplus beats never match len.
               mem_we  = (bresp_q == OKAY) &&
                         (w_cnt_q <= {1'b0, w_len_q});
               w_idx_d = w_idx_q + idx_t'(1);
               if (w_cnt_q != 5'd16)
                  w_cnt_d = w_cnt_q + 5'd1;
               if (AXI_wlast) begin
                  wstate_d = W_RESP;
                  if (w_cnt_q != {1'b0, w_len_q} && bresp_q == OKAY)
                     bresp_d = SLVERR;
               end
            end
         end
         W_RESP: begin
            AXI_bvalid = 1'b1;
            if (AXI_bready)
               wstate_d = W_IDLE;
         end
         default: wstate_d = W_IDLE;
      endcase
   end

   always_ff @(posedge AXI_clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (AXI_wstrb[b])
               mem[w_idx_q][8*b +: 8] <= AXI_wdata[8*b +: 8];
         end
      end
   end

   assign AXI_bid   = bid_q;
   assign AXI_bresp = bresp_q;

   // ---------------- read channel ----------------
   rstate_t         rstate_q, rstate_d;
   idx_t            r_idx_q, r_idx_d;
   logic [3:0]      r_len_q, r_len_d;
   logic [3:0]      r_cnt_q, r_cnt_d;
   logic [1:0]      rresp_q, rresp_d;
   logic [ID_W-1:0] rid_q, rid_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            rvalid_q, rvalid_d;
   logic            rlast_q, rlast_d;
   logic            r_load;
   logic [31:0]     rd_word;

   assign rd_word = mem[r_idx_q];

   always_ff @(posedge AXI_clk or posedge rst) begin
      if (rst) begin
         rstate_q <= R_IDLE;
         r_idx_q  <= '0;
         r_len_q  <= '0;
         r_cnt_q  <= '0;
         rresp_q  <= OKAY;
         rid_q    <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         rlast_q  <= 1'b0;
      end else begin
         rstate_q <= rstate_d;
         r_idx_q  <= r_idx_d;
         r_len_q  <= r_len_d;
         r_cnt_q  <= r_cnt_d;
         rresp_q  <= rresp_d;
         rid_q    <= rid_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         rlast_q  <= rlast_d;
      end
   end

   always_comb begin
      rstate_d    = rstate_q;
      r_idx_d     = r_idx_q;
      r_len_d     = r_len_q;
      r_cnt_d     = r_cnt_q;
      rresp_d     = rresp_q;
      rid_d       = rid_q;
      rdata_d     = rdata_q;
      rvalid_d    = rvalid_q;
      rlast_d     = rlast_q;
      r_load      = 1'b0;
      AXI_arready = 1'b0;
      unique case (rstate_q)
         R_IDLE: begin
            AXI_arready = !rst;
            if (AXI_arvalid && !rst) begin
               r_idx_d  = word_idx(AXI_araddr);
               r_len_d  = AXI_arlen;
               r_cnt_d  = '0;
               rresp_d  = burst_resp(AXI_araddr, AXI_arsize,
                                     AXI_arburst);
               rid_d    = AXI_arid;
               rstate_d = R_FETCH;
            end
         end
         R_FETCH: begin
            r_load   = 1'b1;
            rstate_d = R_DATA;
         end
         R_DATA: begin
            if (AXI_rready) begin
               if (rlast_q) begin
                  rvalid_d = 1'b0;
                  rlast_d  = 1'b0;
                  rstate_d = R_IDLE;
               end else begin
                  r_load = 1'b1;
               end
            end
         end
         default: rstate_d = R_IDLE;
      endcase
      // Registered RAM read: the next beat is staged while the current one drains.
      if (r_load) begin
         rdata_d  = (rresp_q == OKAY) ? rd_word : '0;
         rvalid_d = 1'b1;
         rlast_d  = (r_cnt_q == r_len_q);
         r_idx_d  = r_idx_q + idx_t'(1);
         r_cnt_d  = r_cnt_q + 4'd1;
      end
   end

   assign AXI_rdata  = rdata_q;
   assign AXI_rid    = rid_q;
   assign AXI_rresp  = rresp_q;
   assign AXI_rlast  = rlast_q;
   assign AXI_rvalid = rvalid_q;

endmodule

// File: tb/tb_axi3_ocm_slave.sv
// Bench for axi3_ocm_slave: directed steps plus random bursts
// checked against an array model of the RAM.
module tb_axi3_ocm_slave;

   localparam logic [31:0] BASE  = 32'hfffc0000;
   localparam int          DEPTH = 1024;
   localparam int          IDW   = 12;

   logic           AXI_clk, rst;
   logic [31:0]    AXI_awaddr, AXI_araddr;
   logic [IDW-1:0] AXI_awid, AXI_arid, AXI_bid, AXI_rid;
   logic [3:0]     AXI_awlen, AXI_arlen, AXI_wstrb;
   logic [2:0]     AXI_awsize, AXI_arsize;
   logic [1:0]     AXI_awburst, AXI_arburst, AXI_bresp, AXI_rresp;
   logic           AXI_awvalid, AXI_awready, AXI_wlast;
   logic           AXI_wvalid, AXI_wready, AXI_bvalid, AXI_bready;
   logic           AXI_arvalid, AXI_arready, AXI_rlast;
   logic           AXI_rvalid, AXI_rready;
   logic [31:0]    AXI_wdata, AXI_rdata;

   axi3_ocm_slave dut (
      .AXI_clk(AXI_clk), .rst(rst),
      .AXI_awaddr(AXI_awaddr), .AXI_awid(AXI_awid),
      .AXI_awlen(AXI_awlen), .AXI_awsize(AXI_awsize),
      .AXI_awburst(AXI_awburst), .AXI_awvalid(AXI_awvalid),
      .AXI_awready(AXI_awready), .AXI_wdata(AXI_wdata),
      .AXI_wstrb(AXI_wstrb), .AXI_wlast(AXI_wlast),
      .AXI_wvalid(AXI_wvalid), .AXI_wready(AXI_wready),
      .AXI_bid(AXI_bid), .AXI_bresp(AXI_bresp),
      .AXI_bvalid(AXI_bvalid), .AXI_bready(AXI_bready),
      .AXI_araddr(AXI_araddr), .AXI_arid(AXI_arid),
      .AXI_arlen(AXI_arlen), .AXI_arsize(AXI_arsize),
      .AXI_arburst(AXI_arburst), .AXI_arvalid(AXI_arvalid),
      .AXI_arready(AXI_arready), .AXI_rdata(AXI_rdata),
      .AXI_rid(AXI_rid), .AXI_rresp(AXI_rresp),
      .AXI_rlast(AXI_rlast), .AXI_rvalid(AXI_rvalid),
      .AXI_rready(AXI_rready)
   );

   initial AXI_clk = 1'b0;
   always #5 AXI_clk = ~AXI_clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model [DEPTH];
   logic [31:0] wd [32];
   logic [3:0]  ws [32];
   logic [31:0] last_rdata;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge AXI_clk);
      #1;
   endtask

   function automatic logic [1:0] exp_resp(input logic [31:0] a,
                                           input logic [2:0] sz,
                                           input logic [1:0] bt);
      longint unsigned la, lo, hi;
      la = a;
      lo = BASE;
      hi = lo + 4 * DEPTH;
      if (la < lo || la >= hi) return 2'b11;
      if (sz != 3'd2 || bt != 2'd1) return 2'b10;
      return 2'b00;
   endfunction

   function automatic int widx(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return int'((off / 4) % DEPTH);
   endfunction

   task automatic do_write(input logic [31:0] addr,
                           input logic [IDW-1:0] id,
                           input int len, input int nbeats,
                           input logic [2:0] size,
                           input logic [1:0] burst,
                           input int stall);
      logic [1:0] er;
      int         base, n, k;
      logic       done;
      er   = exp_resp(addr, size, burst);
      base = widx(addr);
      AXI_awaddr  = addr;
      AXI_awid    = id;
      AXI_awlen   = 4'(len);
      AXI_awsize  = size;
      AXI_awburst = burst;
      AXI_awvalid = 1'b1;
      n = 0;
      while (AXI_awready !== 1'b1 && n < 50) begin
         cyc();
         n++;
      end
      check("aw_ready", 32'(AXI_awready), 32'd1);
      cyc();
      AXI_awvalid = 1'b0;
      for (int i = 0; i < nbeats; i++) begin
         while (stall > 0 && $urandom_range(99) < stall) begin
            AXI_wvalid = 1'b0;
            cyc();
         end
         AXI_wvalid = 1'b1;
         AXI_wdata  = wd[i];
         AXI_wstrb  = ws[i];
         AXI_wlast  = (i == nbeats - 1);
         n = 0;
         while (AXI_wready !== 1'b1 && n < 50) begin
            cyc();
            n++;
         end
         check("w_ready", 32'(AXI_wready), 32'd1);
         cyc();
         if (er == 2'b00 && i <= len) begin
            k = (base + i) % DEPTH;
            for (int b = 0; b < 4; b++)
               if (ws[i][b]) model[k][8*b +: 8] = wd[i][8*b +: 8];
         end
      end
      AXI_wvalid = 1'b0;
      AXI_wlast  = 1'b0;
      if (er == 2'b00 && nbeats != len + 1) er = 2'b10;
      done = 1'b0;
      n = 0;
      while (!done && n < 200) begin
         AXI_bready = (stall == 0) ? 1'b1
                      : ($urandom_range(99) >= stall);
         if (AXI_bvalid) begin
            check("bresp", 32'(AXI_bresp), 32'(er));
            check("bid", 32'(AXI_bid), 32'(id));
            if (AXI_bready) done = 1'b1;
         end
         cyc();
         n++;
      end
      AXI_bready = 1'b0;
      check("b_done", 32'(done), 32'd1);
      check("b_single", 32'(AXI_bvalid), 32'd0);
   endtask

   task automatic do_read(input logic [31:0] addr,
                          input logic [IDW-1:0] id,
                          input int len,
                          input logic [2:0] size,
                          input logic [1:0] burst,
                          input int stall, input int abort_at);
      logic [1:0]  er;
      logic [31:0] ex [16];
      int          base, n, beat;
      er   = exp_resp(addr, size, burst);
      base = widx(addr);
      for (int i = 0; i <= len; i++)
         ex[i] = (er == 2'b00) ? model[(base + i) % DEPTH] : 32'd0;
      AXI_araddr  = addr;
      AXI_arid    = id;
      AXI_arlen   = 4'(len);
      AXI_arsize  = size;
      AXI_arburst = burst;
      AXI_arvalid = 1'b1;
      n = 0;
      while (AXI_arready !== 1'b1 && n < 50) begin
         cyc();
         n++;
      end
      check("ar_ready", 32'(AXI_arready), 32'd1);
      cyc();
      AXI_arvalid = 1'b0;
      check("r_lat_n1", 32'(AXI_rvalid), 32'd0);
      cyc();
      check("r_lat_n2", 32'(AXI_rvalid), 32'd1);
      beat = 0;
      n = 0;
      while (beat <= len && n < 300) begin
         if (beat == abort_at) begin
            AXI_rready = 1'b0;
            rst = 1'b1;
            #1;
            check("abort_rvalid", 32'(AXI_rvalid), 32'd0);
            check("abort_rlast", 32'(AXI_rlast), 32'd0);
            check("abort_rdata", AXI_rdata, 32'd0);
            cyc();
            cyc();
            rst = 1'b0;
            cyc();
            return;
         end
         AXI_rready = (stall == 0) ? 1'b1
                      : ($urandom_range(99) >= stall);
         if (stall == 0)
            check("r_nobubble", 32'(AXI_rvalid), 32'd1);
         if (AXI_rvalid) begin
            check("rdata", AXI_rdata, ex[beat]);
            check("rresp", 32'(AXI_rresp), 32'(er));
            check("rid", 32'(AXI_rid), 32'(id));
            check("rlast", 32'(AXI_rlast), 32'(beat == len));
            if (AXI_rready) begin
               last_rdata = AXI_rdata;
               beat++;
            end
         end
         cyc();
         n++;
      end
      AXI_rready = 1'b0;
      check("r_beats", 32'(beat), 32'(len + 1));
      check("r_end", 32'(AXI_rvalid), 32'd0);
   endtask

   initial begin
      logic [31:0] a;
      rst = 1'b1;
      {AXI_awaddr, AXI_awid, AXI_awlen, AXI_awsize} = '0;
      {AXI_awburst, AXI_awvalid, AXI_wdata, AXI_wstrb} = '0;
      {AXI_wlast, AXI_wvalid, AXI_bready} = '0;
      {AXI_araddr, AXI_arid, AXI_arlen, AXI_arsize} = '0;
      {AXI_arburst, AXI_arvalid, AXI_rready} = '0;
      last_rdata = '0;
      repeat (3) cyc();
      check("rst_awready", 32'(AXI_awready), 32'd0);
      check("rst_wready", 32'(AXI_wready), 32'd0);
      check("rst_bvalid", 32'(AXI_bvalid), 32'd0);
      check("rst_arready", 32'(AXI_arready), 32'd0);
      check("rst_rvalid", 32'(AXI_rvalid), 32'd0);
      check("rst_rlast", 32'(AXI_rlast), 32'd0);
      check("rst_bresp", 32'(AXI_bresp), 32'd0);
      check("rst_rresp", 32'(AXI_rresp), 32'd0);
      check("rst_rdata", AXI_rdata, 32'd0);
      check("rst_bid", 32'(AXI_bid), 32'd0);
      check("rst_rid", 32'(AXI_rid), 32'd0);
      rst = 1'b0;
      cyc();
      check("idle_awready", 32'(AXI_awready), 32'd1);

      // Full 16-beat write of 1..16, then read back
      for (int i = 0; i < 16; i++) begin
         wd[i] = 32'(i + 1);
         ws[i] = 4'hF;
      end
      do_write(BASE, 12'h5a3, 15, 16, 3'd2, 2'd1, 0);
      do_read(BASE, 12'h1c7, 15, 3'd2, 2'd1, 0, -1);

      // Fill the rest of the RAM so every model word is defined
      for (int b = 1; b < DEPTH / 16; b++) begin
         for (int i = 0; i < 16; i++) wd[i] = $urandom;
         do_write(BASE + 32'(b * 64), 12'(b), 15, 16,
                  3'd2, 2'd1, 0);
      end

      // Byte-strobe merge
      a = BASE + 32'(100 * 4);
      wd[0] = 32'hAABBCCDD;
      ws[0] = 4'hF;
      do_write(a, 12'h001, 0, 1, 3'd2, 2'd1, 0);
      wd[0] = 32'h11223344;
      ws[0] = 4'b0101;
      do_write(a, 12'h002, 0, 1, 3'd2, 2'd1, 0);
      do_read(a, 12'h003, 0, 3'd2, 2'd1, 0, -1);
      check("strb_merge", last_rdata, 32'hAA22CC44);

      // Error bursts
      do_read(BASE, 12'h010, 15, 3'd1, 2'd1, 0, -1);
      do_read(BASE + 32'(4 * DEPTH), 12'h011, 3, 3'd2, 2'd1, 0, -1);
      for (int i = 0; i < 16; i++) begin
         wd[i] = 32'hDEAD0000 | 32'(i);
         ws[i] = 4'hF;
      end
      do_write(BASE - 32'd4, 12'h012, 15, 16, 3'd2, 2'd1, 0);
      do_write(BASE + 32'd64, 12'h013, 3, 4, 3'd2, 2'd0, 0);
      do_read(BASE, 12'h014, 15, 3'd2, 2'd1, 0, -1);
      do_read(BASE + 32'd64, 12'h015, 3, 3'd2, 2'd1, 0, -1);

      // wlast early / late
      do_write(BASE + 32'd1200, 12'h020, 3, 2, 3'd2, 2'd1, 0);
      do_write(BASE + 32'd1240, 12'h021, 1, 3, 3'd2, 2'd1, 0);
      do_read(BASE + 32'd1200, 12'h022, 3, 3'd2, 2'd1, 0, -1);
      do_read(BASE + 32'd1240, 12'h023, 2, 3'd2, 2'd1, 0, -1);

      // Wrap from last word to word 0 with stalls
      wd[0] = 32'hCAFE0001;
      wd[1] = 32'hCAFE0002;
      ws[0] = 4'hF;
      ws[1] = 4'hF;
      a = BASE + 32'(4 * (DEPTH - 1));
      do_write(a, 12'h030, 1, 2, 3'd2, 2'd1, 40);
      do_read(a, 12'h031, 1, 3'd2, 2'd1, 40, -1);
      do_read(BASE, 12'h032, 0, 3'd2, 2'd1, 0, -1);
      check("wrap_word0", last_rdata, 32'hCAFE0002);

      // Random bursts with stalls
      for (int t = 0; t < 12; t++) begin
         int len;
         len = $urandom_range(15);
         a = BASE + 32'($urandom_range(DEPTH - 1) * 4)
             + 32'($urandom_range(3));
         for (int i = 0; i < 16; i++) begin
            wd[i] = $urandom;
            ws[i] = 4'($urandom);
         end
         do_write(a, 12'($urandom), len, len + 1, 3'd2, 2'd1, 30);
         do_read(a, 12'($urandom), len, 3'd2, 2'd1, 30, -1);
      end

      // AW and AR issued together on disjoint regions
      for (int i = 0; i < 16; i++) begin
         wd[i] = $urandom;
         ws[i] = 4'hF;
      end
      fork
         do_write(BASE + 32'd800, 12'h040, 15, 16, 3'd2, 2'd1, 0);
         do_read(BASE + 32'd1600, 12'h041, 15, 3'd2, 2'd1, 0, -1);
      join
      do_read(BASE + 32'd800, 12'h042, 15, 3'd2, 2'd1, 0, -1);

      // Reset in the middle of a read burst
      do_read(BASE, 12'h050, 15, 3'd2, 2'd1, 0, 5);
      check("post_rst_arready", 32'(AXI_arready), 32'd1);
      do_read(BASE, 12'h051, 15, 3'd2, 2'd1, 0, -1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
